// File: rtl/synapse_integrator.sv
// Sequential synapse integrator: scans one axon per cycle, sums typed weights
// (deterministic or LFSR-stochastic). Define SYN_SATURATE_EN for a saturating accumulator.
module synapse_integrator #(
    parameter int          NUM_AXONS = 16,
    parameter int          WEIGHT_W  = 8,
    parameter int          ACC_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_AXONS-1:0]     axon_spikes,
    input  logic [NUM_AXONS-1:0]     connect,
    input  logic [2*NUM_AXONS-1:0]   axon_types,
    input  logic [4*WEIGHT_W-1:0]    weights,
    input  logic [3:0]               stoch_mode,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         sum_out
);
    localparam int IDX_W = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam logic [ACC_W-1:0] PLUS_ONE  = ACC_W'(1);
    localparam logic [ACC_W-1:0] MINUS_ONE = '1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                   state_reg, state_next;
    logic [NUM_AXONS-1:0]     spikes_reg;
    logic [NUM_AXONS-1:0]     connect_reg;
    logic [2*NUM_AXONS-1:0]   types_reg;
    logic [4*WEIGHT_W-1:0]    weights_reg;
    logic [3:0]               stoch_reg;
    logic [ACC_W-1:0]         acc_reg, acc_next;
    logic [IDX_W-1:0]         idx_reg;
    logic [15:0]              lfsr_reg, lfsr_next;
    logic [ACC_W-1:0]         sum_reg;
    logic                     valid_reg;

    logic [WEIGHT_W-1:0]      rnd;
    logic [WEIGHT_W-1:0]      type_w       [4];
    logic [WEIGHT_W:0]        type_mag     [4];
    logic [ACC_W-1:0]         type_ext     [4];
    logic [ACC_W-1:0]         type_contrib [4];
    logic [1:0]               cur_type;
    logic                     active;
    logic                     last;
    logic [ACC_W-1:0]         contrib;

    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign rnd       = lfsr_reg[WEIGHT_W-1:0];

    // Every type's contribution is formed in parallel against the current LFSR draw;
    // the scanned axon then just picks its type.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_type
            assign type_w[gi]   = weights_reg[gi*WEIGHT_W +: WEIGHT_W];
            assign type_ext[gi] = {{(ACC_W-WEIGHT_W){type_w[gi][WEIGHT_W-1]}}, type_w[gi]};
            assign type_mag[gi] = type_w[gi][WEIGHT_W-1]
                                ? (~{1'b1, type_w[gi]} + {{WEIGHT_W{1'b0}}, 1'b1})
                                : {1'b0, type_w[gi]};
            assign type_contrib[gi] = !stoch_reg[gi] ? type_ext[gi]
                                    : (({1'b0, rnd} < type_mag[gi])
                                        ? (type_w[gi][WEIGHT_W-1] ? MINUS_ONE : PLUS_ONE)
                                        : '0);
        end
    endgenerate

    assign cur_type = types_reg[2*idx_reg +: 2];
    assign active   = spikes_reg[idx_reg] & connect_reg[idx_reg];
    assign contrib  = active ? type_contrib[cur_type] : '0;
    assign last     = (idx_reg == IDX_W'(NUM_AXONS-1));

`ifdef SYN_SATURATE_EN
    logic [ACC_W:0] wide_sum;
    assign wide_sum = {acc_reg[ACC_W-1], acc_reg} + {contrib[ACC_W-1], contrib};
    always_comb begin
        acc_next = wide_sum[ACC_W-1:0];
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            acc_next = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_next = acc_reg + contrib;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spikes_reg  <= '0;
            connect_reg <= '0;
            types_reg   <= '0;
            weights_reg <= '0;
            stoch_reg   <= '0;
            acc_reg     <= '0;
            idx_reg     <= '0;
            lfsr_reg    <= LFSR_SEED;
            sum_reg     <= '0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        spikes_reg  <= axon_spikes;
                        connect_reg <= connect;
                        types_reg   <= axon_types;
                        weights_reg <= weights;
                        stoch_reg   <= stoch_mode;
                        acc_reg     <= '0;
                        idx_reg     <= '0;
                    end
                end
                SCAN: begin
                    acc_reg  <= acc_next;
                    lfsr_reg <= lfsr_next;
                    idx_reg  <= idx_reg + IDX_W'(1);
                    if (last) begin
                        sum_reg   <= acc_next;
                        valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) valid_reg <= 1'b0;
                end
                default: valid_reg <= 1'b0;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign out_valid = valid_reg;
    assign sum_out   = sum_reg;
endmodule

// File: tb/tb_synapse_integrator.sv
// Directed self-checking bench for synapse_integrator (ACC_W=10 so overflow is reachable).
module tb_synapse_integrator;
    localparam int N  = 16;
    localparam int WW = 8;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [N-1:0]    axon_spikes = '0;
    logic [N-1:0]    connect = '0;
    logic [2*N-1:0]  axon_types = '0;
    logic [4*WW-1:0] weights = '0;
    logic [3:0]      stoch_mode = '0;
    logic            busy;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [AW-1:0]   sum_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] lfsr_m;

    synapse_integrator #(.NUM_AXONS(N), .WEIGHT_W(WW), .ACC_W(AW), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .axon_spikes(axon_spikes), .connect(connect),
        .axon_types(axon_types), .weights(weights), .stoch_mode(stoch_mode), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    function automatic int sum_int();
        logic signed [AW-1:0] s;
        s = sum_out;
        return int'(s);
    endfunction

    // Launch a run at the next edge, then scramble the inputs to prove they are not re-sampled.
    task automatic launch(input logic [N-1:0] sp, input logic [N-1:0] cn, input logic [2*N-1:0] ty,
                          input logic [4*WW-1:0] wt, input logic [3:0] sm);
        axon_spikes = sp; connect = cn; axon_types = ty; weights = wt; stoch_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        axon_spikes = ~sp; connect = ~cn; axon_types = ~ty; weights = ~wt; stoch_mode = ~sm;
    endtask

    task automatic wait_valid(input string tag);
        int cycles = 0;
        while (!out_valid && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, cycles, N);
    endtask

    task automatic handshake(input string tag, input int kept);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " idle valid"}, int'(out_valid), 0);
        check({tag, " idle busy"}, int'(busy), 0);
        check({tag, " sum kept"}, sum_int(), kept);
    endtask

    task automatic run_check(input string tag, input logic [N-1:0] sp, input logic [N-1:0] cn,
                             input logic [2*N-1:0] ty, input logic [4*WW-1:0] wt,
                             input logic [3:0] sm, input int expected);
        launch(sp, cn, ty, wt, sm);
        wait_valid(tag);
        check({tag, " sum"}, sum_int(), expected);
        handshake(tag, expected);
    endtask

    // Independent LFSR model: count draws with r < 128 over one full scan.
    function automatic int model_low_draws();
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (lfsr_m[7:0] < 8'd128) cnt++;
            lfsr_m = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
        end
        return cnt;
    endfunction

    initial begin
        int held;
        int exp_ovf;
        int exp_rec;
        int low;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(out_valid), 0);
        check("reset sum", sum_int(), 0);

        // Weights t3..t0 = -4, 10, -1, 5; axon i has type i%4.
        run_check("det", 16'h000F, 16'hFFFF, 32'hE4E4E4E4, 32'hFC0AFF05, 4'b0000, 10);
        run_check("mask none", 16'h000F, 16'h0000, 32'hE4E4E4E4, 32'hFC0AFF05, 4'b0000, 0);
        run_check("mask 4..7", 16'hFFFF, 16'h00F0, 32'h0000E400, 32'hFC0AFF05, 4'b0000, 10);

`ifdef SYN_SATURATE_EN
        exp_ovf = 511;
        exp_rec = 383;
`else
        exp_ovf = -16;
        exp_rec = -271;
`endif
        run_check("overflow", 16'hFFFF, 16'hFFFF, 32'h00000000, 32'h0000007F, 4'b0000, exp_ovf);
        // 15 x +127 then one -128 (axon 15 is type 1).
        run_check("recover", 16'hFFFF, 16'hFFFF, 32'h40000000, 32'h0000807F, 4'b0000, exp_rec);

        // Back-pressure with a start pulse while holding.
        launch(16'h000F, 16'hFFFF, 32'hE4E4E4E4, 32'hFC0AFF05, 4'b0000);
        wait_valid("bp");
        held = sum_int();
        check("bp sum", held, 10);
        for (int c = 0; c < 5; c++) begin
            start = (c == 1);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bp hold%0d sum", c), sum_int(), 10);
            check($sformatf("bp hold%0d busy", c), int'(busy), 1);
        end
        check("bp valid held", int'(out_valid), 1);
        handshake("bp", 10);
        @(negedge clk);
        check("bp no queued start", int'(busy), 0);

        // Reset in the middle of a scan.
        launch(16'hFFFF, 16'hFFFF, 32'h00000000, 32'h00000005, 4'b0001);
        repeat (5) @(negedge clk);
        check("mid scan busy", int'(busy), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort valid", int'(out_valid), 0);
        check("abort sum", sum_int(), 0);
        lfsr_m = 16'hACE1;

        low = model_low_draws();
        run_check("stoch -128", 16'hFFFF, 16'hFFFF, 32'h00000000, 32'h00000080, 4'b0001, -low);
        low = model_low_draws();
        run_check("stoch zero", 16'hFFFF, 16'hFFFF, 32'h00000000, 32'h00000000, 4'b0001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/synapse_integrator.md
Name: synapse_integrator

Overview:
- Parametrised, sequential successor to the single-synapse combinational unit.
- For one neuron per tick, scans NUM_AXONS axon spike lines one axon per cycle and applies crossbar connectivity.
- Each connected axon selects one of four signed per-type weights by its axon type; each type is integrated deterministically or stochastically using an internal LFSR.
- Delivers a signed accumulated synaptic sum to the downstream neuron membrane update through a valid/ready handshake.

Parameters:
- NUM_AXONS, 16, number of axon inputs scanned per tick (>=2).
- WEIGHT_W, 8, width of each signed type weight.
- ACC_W, 16, width of the signed accumulator and sum output (> WEIGHT_W).
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR (must be nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin integration; accepted only in IDLE.
- axon_spikes  in  NUM_AXONS  spike vector for this tick.
- connect  in  NUM_AXONS  crossbar row for this neuron; 1 = connected.
- axon_types  in  2*NUM_AXONS  2-bit type per axon; axon i uses bits [2i+1:2i].
- weights  in  4*WEIGHT_W  signed weight per type; type t uses bits [(t+1)*WEIGHT_W-1 : t*WEIGHT_W].
- stoch_mode  in  4  per-type mode; 1 = stochastic, 0 = deterministic.
- busy  out  1  high in SCAN and HOLD.
- out_valid  out  1  sum_out is valid.
- out_ready  in  1  consumer accepts sum_out.
- sum_out  out  ACC_W  signed accumulated synaptic input.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, out_valid=0, sum_out=0, accumulator=0, index=0, LFSR=LFSR_SEED. Reset in any state, including mid-SCAN or HOLD, aborts the run with no output.
- FSM states: IDLE, SCAN, HOLD.
- IDLE -> SCAN on start.
  - All inputs except out_ready are registered on this edge and never re-sampled during the run.
  - Accumulator and index are cleared.
- SCAN, one axon per cycle, index 0..NUM_AXONS-1.
  - An axon is active when spike[i] and connect[i] are both 1; its weight is w = weights[type].
  - Deterministic type: contribution = w, sign-extended to ACC_W.
  - Stochastic type:
    - mag = |w| as unsigned WEIGHT_W+1 bits (so -2^(WEIGHT_W-1) gives 2^(WEIGHT_W-1)).
    - r = LFSR[WEIGHT_W-1:0].
    - If r < mag: contribution = +1 for w>0, -1 for w<0. Otherwise contribution = 0.
    - w = 0 always contributes 0.
  - Inactive axon: contribution = 0.
  - The accumulator adds the contribution every SCAN cycle.
  - After index NUM_AXONS-1 is processed -> HOLD; sum_out takes the final accumulator value and out_valid goes to 1 on the same edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left with feedback into bit 0.
  - Advances exactly once per SCAN cycle, whether or not the axon is active or stochastic.
  - Holds in IDLE and HOLD.
  - Sequence is fully deterministic from reset.
- HOLD:
  - out_valid=1; sum_out stable.
  - When out_valid && out_ready -> IDLE, out_valid=0; sum_out keeps its last value.
- Latency: start accepted at edge k; out_valid rises at edge k+NUM_AXONS; earliest next start is accepted the cycle after the handshake.
- start is ignored while busy; no queuing.
- out_ready is ignored when out_valid=0.
- Arithmetic: signed two's complement throughout; overflow handling depends on SYN_SATURATE_EN.

Optional Feature:
- Macro: SYN_SATURATE_EN.
- Defined: each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once clamped, later opposite-sign contributions move away from the rail normally.
- Undefined: accumulator wraps modulo 2^ACC_W.

Test Plan:
- Reset: hold rst 3 cycles mid-SCAN -> next cycle busy=0, out_valid=0, sum_out=0; next run's LFSR sequence starts again from 16'hACE1.
- Deterministic run:
  - Stimulus: spikes=16'h000F, connect=16'hFFFF, types axon0..3 = 0,1,2,3, weights t0=5, t1=-1, t2=10, t3=-4, stoch_mode=0, start at edge k.
  - Response: out_valid rises at edge k+16; sum_out=10.
- Masking: same run with connect=16'h0000 -> sum_out=0. Then with spikes=16'hFFFF, connect=16'h00F0 -> only axons 4..7 contribute.
- Overflow (ACC_W=10, all 16 axons active, type 0, w=127):
  - With SYN_SATURATE_EN: sum_out=511.
  - Without: sum_out=-16 (2032 mod 1024 reinterpreted as signed).
- Stochastic run:
  - Setup: stoch_mode=4'b0001, w0=-128, all 16 axons active with type 0.
  - Required: sum_out equals the reference-model count of LFSR draws with r<128, negated. Repeat with w0=0 -> sum_out=0.
- Back-pressure: out_ready low for 5 cycles after out_valid, with start pulsed during HOLD -> sum_out stable, start ignored, busy=1. Raising out_ready returns the block to IDLE on the next edge.
